lower_part_or_carry_lookahead_adder32_aor_enc64: RTL and testbench

- Logic-locked, approximate 32-bit adder of the lower-part-OR (LOA) type.
- The low LOWER_WIDTH bits are approximated by a bitwise OR of the operands. The upper bits are added exactly with a 4-bit-block carry-lookahead adder.
- A 64-bit key gates both operands through XOR/XNOR key gates. Only the correct key reproduces the unlocked function; any wrong key corrupts the result deterministically.
- The 33-bit result is registered once. The block is used for obfuscation and hamming-distance corruption studies.

---
 rtl/lower_part_or_carry_lookahead_adder32_aor_enc64.sv | 96 +++++++++
 tb/tb_lower_part_or_carry_lookahead_adder32_aor_enc64.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lower_part_or_carry_lookahead_adder32_aor_enc64.sv
// Key-locked 32-bit lower-part-OR approximate adder.
// The low LOWER_WIDTH bits are ORed and the upper bits go through 4-bit CLA blocks.
// The 33-bit sum is registered once, so latency is one cycle.
module lower_part_or_carry_lookahead_adder32_aor_enc64 #(
  parameter int          LOWER_WIDTH = 8,
  parameter logic [63:0] CORRECT_KEY = 64'h9634809C305E141C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] add1_i,
  input  logic [31:0] add2_i,
  input  logic [63:0] keyinput,
  output logic [32:0] result_o
);

  // Upper (exact) part width, number of 4-bit CLA blocks, and padded width.
  localparam int UW = 32 - LOWER_WIDTH;
  localparam int NB = (UW + 3) / 4;
  localparam int PW = NB * 4;

  logic [31:0] aEff;
  logic [31:0] bEff;
  logic [LOWER_WIDTH-1:0] lowOr;
  logic cinUp;
  logic [PW-1:0] aUp;
  logic [PW-1:0] bUp;
  logic [PW-1:0] gUp;
  logic [PW-1:0] pUp;
  logic [PW:0] cUp;
  logic [NB:0] blkC;
  logic [32:0] result_d;
  logic [32:0] result_q;

  // Key gates: a matching key bit cancels the built-in inversion, a wrong one flips the operand bit.
  assign aEff = add1_i ^ keyinput[31:0] ^ CORRECT_KEY[31:0];
  assign bEff = add2_i ^ keyinput[63:32] ^ CORRECT_KEY[63:32];

  // Approximate lower part; its top bit pair still generates the carry into the exact part.
  assign lowOr = aEff[LOWER_WIDTH-1:0] | bEff[LOWER_WIDTH-1:0];
  assign cinUp = aEff[LOWER_WIDTH-1] & bEff[LOWER_WIDTH-1];

  // Upper operands zero-padded to whole blocks; padded bits have g = p = 0.
  assign aUp = PW'(aEff[31:LOWER_WIDTH]);
  assign bUp = PW'(bEff[31:LOWER_WIDTH]);
  assign gUp = aUp & bUp;
  assign pUp = aUp ^ bUp;

  assign blkC[0] = cinUp;

  for (genvar b = 0; b < NB; b++) begin : g_cla
    logic [3:0] g;
    logic [3:0] p;
    logic       c0;
    logic       blkG;
    logic       blkP;

    assign g  = gUp[4*b +: 4];
    assign p  = pUp[4*b +: 4];
    assign c0 = blkC[b];

    // Internal carries in two-level lookahead form from the block carry-in.
    assign cUp[4*b]     = c0;
    assign cUp[4*b + 1] = g[0] | (p[0] & c0);
    assign cUp[4*b + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign cUp[4*b + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c0);

    // Block group generate/propagate feed the block-level carry chain.
    assign blkG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign blkP = &p;
    assign blkC[b + 1] = blkG | (blkP & c0);
  end

  assign cUp[PW] = blkC[NB];

  // Assemble the next result: OR part low, exact sum above, carry-out taken at the real upper width.
  always_comb begin
    result_d = '0;
    result_d[LOWER_WIDTH-1:0] = lowOr;
    result_d[31:LOWER_WIDTH]  = pUp[UW-1:0] ^ cUp[UW-1:0];
    result_d[32]              = cUp[UW];
  end

  // Single output register; reset clears it immediately and discards any in-flight sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_lower_part_or_carry_lookahead_adder32_aor_enc64.sv
// Self-checking bench for the key-locked LOA adder using a scoreboard queue.
module tb_lower_part_or_carry_lookahead_adder32_aor_enc64;

  localparam int          L  = 8;
  localparam logic [63:0] CK = 64'h9634809C305E141C;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] add1_i;
  logic [31:0] add2_i;
  logic [63:0] keyinput;
  logic [32:0] result_o;

  logic [32:0] expQ[$];
  string       tagQ[$];
  int          total = 0;
  int          bad   = 0;

  lower_part_or_carry_lookahead_adder32_aor_enc64 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .add1_i  (add1_i),
    .add2_i  (add2_i),
    .keyinput(keyinput),
    .result_o(result_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  // Golden LOA model written with plain shifts and adds.
  function automatic logic [32:0] loaModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] key);
    logic [31:0] ae;
    logic [31:0] be;
    logic [31:0] mask;
    logic [32:0] up;
    logic        cin;
    ae   = a ^ key[31:0] ^ CK[31:0];
    be   = b ^ key[63:32] ^ CK[63:32];
    mask = (32'h1 << L) - 32'h1;
    cin  = ae[L-1] & be[L-1];
    up   = 33'(ae >> L) + 33'(be >> L) + 33'(cin);
    return (up << L) | 33'((ae | be) & mask);
  endfunction

  task automatic compare(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operand set at the falling edge and record what the next rising edge must load.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] key, input logic [32:0] exp,
                               input string tag);
    @(negedge clk_i);
    add1_i   = a;
    add2_i   = b;
    keyinput = key;
    expQ.push_back(exp);
    tagQ.push_back(tag);
  endtask

  // Let the rising edge happen, then pop the oldest expectation and compare.
  task automatic checkOutput();
    @(posedge clk_i);
    #1;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", result_o);
    end else begin
      compare(tagQ.pop_front(), result_o, expQ.pop_front());
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [63:0] key,
                      input logic [32:0] exp, input string tag);
    applyStimulus(a, b, key, exp, tag);
    checkOutput();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] flip;
    logic [63:0] key;
    int          cnt;
    int          idx;

    rst_i    = 1'b1;
    add1_i   = 32'h0;
    add2_i   = 32'h0;
    keyinput = CK;

    #12;
    compare("reset_state", result_o, 33'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Correct key, lower-part OR and carry into the exact part.
    step(32'h000000F0, 32'h0000000F, CK, 33'h0_000000FF, "or_low");
    step(32'h00000180, 32'h00000080, CK, 33'h0_00000280, "cin_bit7");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, CK, 33'h1_FFFFFFFF, "carry_out");
    step(32'h00000000, 32'h00000000, CK, 33'h0_00000000, "zero");
    step(32'h12345678, 32'h0FEDCBA9, CK, loaModel(32'h12345678, 32'h0FEDCBA9, CK), "mixed");

    // Wrong key corrupts exactly the flipped operand bits.
    step(32'h0, 32'h0, 64'h9634809C305E140C, 33'h0_00000010, "wrong_bit4");
    step(32'h0, 32'h0, 64'h9634809C305E142C, 33'h0_00000030, "wrong_bits45");
    step(32'h0, 32'h0, 64'h8634809C305E141C, 33'h0_10000000, "wrong_bit60");

    // Asynchronous reset with a nonzero result held in the register.
    step(32'hFFFFFFFF, 32'hFFFFFFFF, CK, 33'h1_FFFFFFFF, "pre_reset");
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    compare("reset_async", result_o, 33'h0);
    @(posedge clk_i);
    #1;
    compare("reset_hold1", result_o, 33'h0);
    @(posedge clk_i);
    #1;
    compare("reset_hold2", result_o, 33'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset landing on an in-flight operand set discards that result.
    applyStimulus(32'h00001000, 32'h00002000, CK, 33'h0_00003000, "discarded");
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    compare("reset_discard", result_o, 33'h0);
    expQ.delete();
    tagQ.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(32'h00001000, 32'h00002000, CK, 33'h0_00003000, "first_after_reset");

    // Back-to-back random operands with the correct key.
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      b = $urandom();
      step(a, b, CK, loaModel(a, b, CK), "stream_ck");
    end

    // Hamming-distance 1..6 keys against the model with flipped operands.
    for (int hd = 1; hd <= 6; hd++) begin
      for (int t = 0; t < 5; t++) begin
        flip = 64'h0;
        cnt  = 0;
        while (cnt < hd) begin
          idx = $urandom_range(63, 0);
          if (!flip[idx]) begin
            flip[idx] = 1'b1;
            cnt++;
          end
        end
        key = CK ^ flip;
        a   = $urandom();
        b   = $urandom();
        step(a, b, key, loaModel(a, b, key), $sformatf("hd%0d_key", hd));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
